// File: rtl/l1_cache_pkg.sv
// Shared L1 data cache encodings: command codes, L2 message codes, MESI states and the
// command-arbiter FSM states, plus per-source command legality helpers.
package l1_cache_pkg;

    localparam int unsigned L1_CMD_W = 3;

    typedef enum logic [L1_CMD_W-1:0] {
        CmdRead          = 3'd0,
        CmdWrite         = 3'd1,
        CmdInvalidate    = 3'd2,
        CmdClear         = 3'd3,
        CmdL2DataRequest = 3'd4
    } l1_cmd_e;

    typedef enum logic [1:0] {
        L2MsgGetLine        = 2'd0,
        L2MsgSendLine       = 2'd1,
        L2MsgInvalidateLine = 2'd2,
        L2MsgEvictLine      = 2'd3
    } l2_msg_e;

    typedef enum logic [1:0] {
        MesiInvalid   = 2'd0,
        MesiShared    = 2'd1,
        MesiExclusive = 2'd2,
        MesiModified  = 2'd3
    } mesi_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StWaitDone
    } arb_state_e;

    function automatic logic is_cpu_cmd(logic [L1_CMD_W-1:0] c);
        return (c == CmdRead) || (c == CmdWrite) || (c == CmdClear);
    endfunction

    function automatic logic is_snp_cmd(logic [L1_CMD_W-1:0] c);
        return (c == CmdInvalidate) || (c == CmdL2DataRequest);
    endfunction

endpackage

// File: rtl/l1_cmd_arbiter_if.sv
// Requester and cache handshake bundle for the L1 command arbiter.
// slave = arbiter side, master = requesters plus cache side.
interface l1_cmd_arbiter_if #(
    parameter int unsigned ADDR_W = 60,
    parameter int unsigned CMD_W  = 3
);
    logic              cpu_valid;
    logic              cpu_ready;
    logic [CMD_W-1:0]  cpu_cmd;
    logic [ADDR_W-1:0] cpu_addr;
    logic              snp_valid;
    logic              snp_ready;
    logic [CMD_W-1:0]  snp_cmd;
    logic [ADDR_W-1:0] snp_addr;
    logic              cache_write;
    logic [CMD_W-1:0]  cache_command;
    logic [ADDR_W-1:0] cache_address;
    logic              cache_processing;

    modport slave (
        input  cpu_valid, cpu_cmd, cpu_addr,
        output cpu_ready,
        input  snp_valid, snp_cmd, snp_addr,
        output snp_ready,
        output cache_write, cache_command, cache_address,
        input  cache_processing
    );

    modport master (
        output cpu_valid, cpu_cmd, cpu_addr,
        input  cpu_ready,
        output snp_valid, snp_cmd, snp_addr,
        input  snp_ready,
        input  cache_write, cache_command, cache_address,
        output cache_processing
    );

endinterface

// File: rtl/l1_cmd_fifo.sv
// Synchronous FIFO with full/empty flags; a push is ignored while full even if a pop
// happens in the same cycle.
module l1_cmd_fifo #(
    parameter int unsigned WIDTH = 63,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/l1_cmd_arbiter.sv
// L1 data cache command front-end: buffers CPU and snoop requests, arbitrates with snoop
// priority bounded by a CPU anti-starvation limit, and drives the cache handshake.
module l1_cmd_arbiter
    import l1_cache_pkg::*;
#(
    parameter int unsigned ADDR_W       = 60,
    parameter int unsigned CMD_W        = 3,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ACK_TIMEOUT  = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    l1_cmd_arbiter_if.slave  bus,
    output logic             busy,
    output logic             grant_src,
    output logic [CNT_W-1:0] cpu_issued,
    output logic [CNT_W-1:0] snp_issued,
    output logic [CNT_W-1:0] dropped,
    output logic             timeout_err
);
    localparam int unsigned ENTRY_W  = CMD_W + ADDR_W;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TMO_W    = $clog2(ACK_TIMEOUT) + 1;

    logic               cpu_full, cpu_empty, snp_full, snp_empty;
    logic               cpu_pop, snp_pop;
    logic [ENTRY_W-1:0] cpu_head, snp_head;

    arb_state_e         state_q;
    logic               write_q, grant_src_q, timeout_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   cpu_cnt_q, snp_cnt_q, drop_cnt_q;
    logic [STARVE_W-1:0] starve_q;
    logic [TMO_W-1:0]   tmo_q;

    logic               can_pick, pick_snp, head_legal;
    logic [CMD_W-1:0]   head_cmd;
    logic [ADDR_W-1:0]  head_addr;

    l1_cmd_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_cpu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cpu_valid),
        .din   ({bus.cpu_cmd, bus.cpu_addr}),
        .full  (cpu_full),
        .pop   (cpu_pop),
        .dout  (cpu_head),
        .empty (cpu_empty)
    );

    l1_cmd_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_snp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.snp_valid),
        .din   ({bus.snp_cmd, bus.snp_addr}),
        .full  (snp_full),
        .pop   (snp_pop),
        .dout  (snp_head),
        .empty (snp_empty)
    );

    assign bus.cpu_ready     = !cpu_full;
    assign bus.snp_ready     = !snp_full;
    assign bus.cache_write   = write_q;
    assign bus.cache_command = cmd_q;
    assign bus.cache_address = addr_q;
    assign busy              = (state_q != StIdle);
    assign grant_src         = grant_src_q;
    assign cpu_issued        = cpu_cnt_q;
    assign snp_issued        = snp_cnt_q;
    assign dropped           = drop_cnt_q;
    assign timeout_err       = timeout_q;

    // Illegal heads are popped here too, so the winner is popped whenever IDLE picks.
    always_comb begin
        pick_snp   = !snp_empty && (cpu_empty || (starve_q < STARVE_W'(STARVE_LIMIT)));
        can_pick   = (state_q == StIdle) && !bus.cache_processing && !(cpu_empty && snp_empty);
        head_cmd   = pick_snp ? snp_head[ENTRY_W-1 -: CMD_W] : cpu_head[ENTRY_W-1 -: CMD_W];
        head_addr  = pick_snp ? snp_head[ADDR_W-1:0] : cpu_head[ADDR_W-1:0];
        head_legal = pick_snp ? is_snp_cmd(head_cmd) : is_cpu_cmd(head_cmd);
        cpu_pop    = can_pick && !pick_snp;
        snp_pop    = can_pick && pick_snp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            grant_src_q <= 1'b0;
            timeout_q   <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            cpu_cnt_q   <= '0;
            snp_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            starve_q    <= '0;
            tmo_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (can_pick) begin
                        if (head_legal) begin
                            cmd_q       <= head_cmd;
                            addr_q      <= head_addr;
                            grant_src_q <= pick_snp;
                            write_q     <= 1'b1;
                            state_q     <= StIssue;
                        end else begin
                            drop_cnt_q <= drop_cnt_q + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    write_q <= 1'b0;
                    tmo_q   <= '0;
                    if (grant_src_q) snp_cnt_q <= snp_cnt_q + 1'b1;
                    else             cpu_cnt_q <= cpu_cnt_q + 1'b1;
                    state_q <= StWaitAck;
                end
                StWaitAck: begin
                    if (bus.cache_processing) begin
                        state_q <= StWaitDone;
                    end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!bus.cache_processing) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (can_pick && head_legal && pick_snp && !cpu_empty) begin
                if (starve_q != STARVE_W'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
            end else if (cpu_empty || (can_pick && head_legal && !pick_snp)) begin
                starve_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_l1_cmd_arbiter.sv
// Directed bench for l1_cmd_arbiter: a small cache model answers cache_write, and a negedge
// monitor logs every issued command and watches command/address stability while busy.
module tb_l1_cmd_arbiter;
    import l1_cache_pkg::*;

    localparam int unsigned ADDR_W = 60;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned CNT_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_cmd_arbiter_if #(.ADDR_W(ADDR_W), .CMD_W(CMD_W)) bus ();

    logic             busy, grant_src, timeout_err;
    logic [CNT_W-1:0] cpu_issued, snp_issued, dropped;

    l1_cmd_arbiter #(
        .ADDR_W       (ADDR_W),
        .CMD_W        (CMD_W),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (4),
        .ACK_TIMEOUT  (8),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .grant_src   (grant_src),
        .cpu_issued  (cpu_issued),
        .snp_issued  (snp_issued),
        .dropped     (dropped),
        .timeout_err (timeout_err)
    );

    // Cache model: processing rises one cycle after a write is seen and holds two cycles.
    logic       force_high = 1'b0;
    logic       never_ack  = 1'b0;
    logic       proc_m     = 1'b0;
    logic [1:0] seq        = 2'd0;
    assign bus.cache_processing = proc_m;

    always @(posedge clk) begin
        if (force_high) begin
            proc_m <= 1'b1;
            seq    <= 2'd0;
        end else if (never_ack) begin
            proc_m <= 1'b0;
            seq    <= 2'd0;
        end else begin
            case (seq)
                2'd0: begin
                    proc_m <= 1'b0;
                    if (bus.cache_write) seq <= 2'd1;
                end
                2'd1: begin
                    proc_m <= 1'b1;
                    seq    <= 2'd2;
                end
                2'd2:    seq <= 2'd3;
                default: begin
                    proc_m <= 1'b0;
                    seq    <= 2'd0;
                end
            endcase
        end
    end

    int                n_wr = 0;
    int                viol = 0;
    int                wide = 0;
    logic              prev_wr = 1'b0;
    logic [ADDR_W-1:0] lat_addr = '0;
    logic [CMD_W-1:0]  lat_cmd = '0;
    logic [ADDR_W-1:0] log_addr [64];
    logic [CMD_W-1:0]  log_cmd [64];
    logic              log_src [64];

    always @(negedge clk) begin
        if (bus.cache_write) begin
            if (n_wr < 64) begin
                log_addr[n_wr] = bus.cache_address;
                log_cmd[n_wr]  = bus.cache_command;
                log_src[n_wr]  = grant_src;
            end
            n_wr++;
            lat_addr = bus.cache_address;
            lat_cmd  = bus.cache_command;
            if (prev_wr) wide++;
        end else if (busy && (bus.cache_address != lat_addr || bus.cache_command != lat_cmd)) begin
            viol++;
        end
        prev_wr = bus.cache_write;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.cpu_valid = 1'b0;
        bus.snp_valid = 1'b0;
        force_high    = 1'b0;
        never_ack     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Holds valid until the FIFO reports ready, then returns one negedge after the push edge.
    task automatic push(input logic src, input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] a);
        bit ok = 1'b0;
        if (src) begin
            bus.snp_cmd = cmd; bus.snp_addr = a; bus.snp_valid = 1'b1;
        end else begin
            bus.cpu_cmd = cmd; bus.cpu_addr = a; bus.cpu_valid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            if (src ? bus.snp_ready : bus.cpu_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.cpu_valid = 1'b0;
        bus.snp_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic wait_idle(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (n_wr >= target && !busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_reached", ok, 1);
        repeat (2) @(negedge clk);
    endtask

    int         base;
    int         k;
    logic [7:0] ord;

    initial begin
        bus.cpu_valid = 1'b0; bus.cpu_cmd = '0; bus.cpu_addr = '0;
        bus.snp_valid = 1'b0; bus.snp_cmd = '0; bus.snp_addr = '0;
        @(negedge clk);
        do_reset();

        chk("rst_cpu_ready", bus.cpu_ready, 1);
        chk("rst_snp_ready", bus.snp_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_write", bus.cache_write, 0);
        chk("rst_cmd_addr", {bus.cache_command, bus.cache_address}, 0);
        chk("rst_counters", {cpu_issued, snp_issued} | 64'(dropped), 0);
        chk("rst_grant_tmo", {grant_src, timeout_err}, 0);

        // Single CPU READ.
        base = n_wr;
        push(1'b0, CmdRead, 60'h123_4567_8000);
        @(negedge clk);
        chk("t1_write", bus.cache_write, 1);
        chk("t1_cmd", bus.cache_command, 0);
        chk("t1_addr", bus.cache_address, 60'h123_4567_8000);
        chk("t1_src", grant_src, 0);
        @(negedge clk);
        chk("t1_write_one_cycle", bus.cache_write, 0);
        chk("t1_busy", busy, 1);
        wait_idle(base + 1);
        chk("t1_cpu_issued", cpu_issued, 1);
        chk("t1_n_writes", n_wr - base, 1);
        chk("t1_busy_done", busy, 0);

        // Arbitration with starvation limit.
        do_reset();
        base       = n_wr;
        force_high = 1'b1;
        push(1'b0, CmdRead, 60'h10);
        push(1'b0, CmdRead, 60'h20);
        for (int i = 0; i < 4; i++) push(1'b1, CmdInvalidate, 60'h100 + 60'(i));
        force_high = 1'b0;
        push(1'b1, CmdInvalidate, 60'h104);
        push(1'b1, CmdInvalidate, 60'h105);
        wait_idle(base + 8);
        ord = '0;
        for (int i = 0; i < 8; i++) ord[7-i] = log_src[base+i];
        chk("t2_order", ord, 8'b1111_0110);
        chk("t2_snp_issued", snp_issued, 6);
        chk("t2_cpu_issued", cpu_issued, 2);
        chk("t2_first", {log_cmd[base], log_addr[base]}, {3'd2, 60'h100});
        chk("t2_cpu_a", log_addr[base+4], 60'h10);
        chk("t2_cpu_b", log_addr[base+7], 60'h20);
        chk("t2_snp_last", log_addr[base+6], 60'h105);

        // FIFO full back-pressure.
        do_reset();
        base       = n_wr;
        force_high = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b0, CmdWrite, 60'h200 + 60'(i));
        chk("t3_ready_after3", bus.cpu_ready, 1);
        push(1'b0, CmdWrite, 60'h203);
        chk("t3_ready_after4", bus.cpu_ready, 0);
        bus.cpu_cmd = CmdWrite; bus.cpu_addr = 60'h204; bus.cpu_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_still_full", bus.cpu_ready, 0);
        force_high = 1'b0;
        push(1'b0, CmdWrite, 60'h204);
        wait_idle(base + 5);
        for (int i = 0; i < 5; i++) chk("t3_order", log_addr[base+i], 60'h200 + 60'(i));
        chk("t3_cpu_issued", cpu_issued, 5);

        // Illegal CPU command dropped.
        do_reset();
        base = n_wr;
        push(1'b0, 3'd2, 60'hAA);
        push(1'b0, CmdRead, 60'hBB);
        wait_idle(base + 1);
        repeat (5) @(negedge clk);
        chk("t4_dropped", dropped, 1);
        chk("t4_n_writes", n_wr - base, 1);
        chk("t4_addr", log_addr[base], 60'hBB);
        chk("t4_cpu_issued", cpu_issued, 1);

        // Ack timeout.
        do_reset();
        base      = n_wr;
        never_ack = 1'b1;
        push(1'b0, CmdRead, 60'h1);
        push(1'b0, CmdRead, 60'h2);
        for (int i = 0; i < 20; i++) begin
            if (bus.cache_write) break;
            @(negedge clk);
        end
        chk("t5_issue", bus.cache_write, 1);
        chk("t5_tmo_before", timeout_err, 0);
        k = 0;
        @(negedge clk);
        while (busy && k < 50) begin
            k++;
            @(negedge clk);
        end
        chk("t5_wait_cycles", k, 8);
        chk("t5_tmo_set", timeout_err, 1);
        chk("t5_idle", busy, 0);
        never_ack = 1'b0;
        wait_idle(base + 2);
        chk("t5_next_issued", cpu_issued, 2);
        chk("t5_next_addr", log_addr[base+1], 60'h2);
        chk("t5_tmo_sticky", timeout_err, 1);

        // Reset during WAIT_DONE with entries queued.
        do_reset();
        base = n_wr;
        push(1'b0, CmdRead, 60'h77);
        for (int i = 0; i < 20; i++) begin
            if (bus.cache_write) break;
            @(negedge clk);
        end
        force_high = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b0, CmdWrite, 60'h80 + 60'(i));
        chk("t6_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_write", bus.cache_write, 0);
        chk("t6_counters", {cpu_issued, snp_issued} | 64'(dropped), 0);
        chk("t6_addr", bus.cache_address, 0);
        chk("t6_ready", {bus.cpu_ready, bus.snp_ready}, 2'b11);
        rst        = 1'b0;
        force_high = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_fifo_empty", n_wr - base, 1);
        chk("t6_cpu_issued_after", cpu_issued, 0);

        chk("addr_stable", viol, 0);
        chk("write_single_cycle", wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_cmd_arbiter.md
Name: l1_cmd_arbiter

Overview:
- Front-end sequencer for the L1 data cache command port.
- Accepts commands from two requesters:
  - CPU/trace side: READ, WRITE, CLEAR.
  - L2 snoop side: INVALIDATE, L2DATAREQUEST.
- Buffers each requester in its own small FIFO and arbitrates between them with snoop priority and a CPU anti-starvation limit.
- Drives the cache's write/command/address handshake, holding each command until the cache's processing flag completes a full rise/fall cycle.

Parameters:
- ADDR_W, 60, address width to cache
- CMD_W, 3, command code width
- FIFO_DEPTH, 4, entries per requester FIFO (power of 2)
- STARVE_LIMIT, 4, max consecutive snoop grants while CPU FIFO non-empty
- ACK_TIMEOUT, 8, cycles to wait for processing rise after issue
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_valid  in  1  CPU request valid
- cpu_ready  out  1  CPU FIFO can accept (= !cpu_full)
- cpu_cmd  in  CMD_W  CPU command code
- cpu_addr  in  ADDR_W  CPU address
- snp_valid  in  1  snoop request valid
- snp_ready  out  1  snoop FIFO can accept (= !snp_full)
- snp_cmd  in  CMD_W  snoop command code
- snp_addr  in  ADDR_W  snoop address
- cache_write  out  1  one-cycle command strobe to cache
- cache_command  out  CMD_W  command to cache
- cache_address  out  ADDR_W  address to cache
- cache_processing  in  1  cache busy flag
- busy  out  1  FSM not IDLE
- grant_src  out  1  source of in-flight command (0 = CPU, 1 = snoop)
- cpu_issued  out  CNT_W  CPU commands issued
- snp_issued  out  CNT_W  snoop commands issued
- dropped  out  CNT_W  illegal commands discarded
- timeout_err  out  1  sticky: ACK_TIMEOUT expired

Behaviour:
- Reset values:
  - FSM IDLE; both FIFOs empty; cpu_ready = snp_ready = 1 while rst is deasserted.
  - cache_write = 0; cache_command = 0; cache_address = 0.
  - busy = 0; grant_src = 0; all counters 0; timeout_err = 0; starve counter 0.
- Reset mid-operation aborts the in-flight command, drops all buffered entries, and returns to IDLE the next cycle.
- FIFO push: a push occurs on valid && ready at a clock edge.
  - ready = !full only; no push while full, even if a pop occurs in the same cycle.
  - Push and pop on a non-full, non-empty FIFO in the same cycle keep the count unchanged.
- Legal commands per source:
  - CPU: READ=0, WRITE=1, CLEAR=3.
  - Snoop: INVALIDATE=2, L2DATAREQUEST=4.
  - An illegal head entry is popped in IDLE without issue: dropped += 1, no cache_write, stays IDLE.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Stays IDLE if cache_processing = 1 or both FIFOs are empty.
  - Otherwise selects a source:
    - Snoop wins if snp non-empty and (cpu empty or starve_cnt < STARVE_LIMIT); else CPU.
  - Pops the winner; registers cache_command, cache_address, grant_src; goes to ISSUE.
- ISSUE: cache_write = 1 for exactly this one cycle; increments the winner's issued counter; goes to WAIT_ACK.
- WAIT_ACK:
  - cache_write = 0.
  - On cache_processing = 1, goes to WAIT_DONE.
  - After ACK_TIMEOUT cycles without a rise: sets timeout_err and goes to IDLE.
- WAIT_DONE: on cache_processing = 0, goes to IDLE.
- cache_command and cache_address stay constant from the ISSUE cycle until WAIT_DONE exits. The cache reads its set index combinationally during processing, so they must not change earlier.
- Starve counter:
  - +1 (saturating at STARVE_LIMIT) on a snoop grant while the CPU FIFO is non-empty.
  - Cleared on any CPU grant or when the CPU FIFO is empty.
- Latency: an entry pushed at edge N into an empty FIFO, with the FSM IDLE and processing low, produces cache_write high during the cycle after edge N+1.
- Back-to-back throughput: at most one command per 4 cycles, plus the cache's processing time.
- busy = (state != IDLE).
- Counters wrap modulo 2^CNT_W.

Decomposition:
- Package l1_cache_pkg:
  - Command codes READ/WRITE/INVALIDATE/CLEAR/L2DATAREQUEST.
  - L2 message codes.
  - MESI encodings.
  - FSM state enum.
- Sub-module l1_cmd_fifo: synchronous FIFO, width CMD_W+ADDR_W, depth FIFO_DEPTH, with full/empty flags; instantiated twice.

Test Plan:
- Single CPU READ at addr 0x123_4567_8000, cache model raises processing 1 cycle after write and holds it 2 cycles:
  - cache_write high exactly 1 cycle, command = 0, address stable until processing falls.
  - cpu_issued = 1; busy returns to 0.
- Both FIFOs loaded, CPU with 2 READs and snoop with 6 INVALIDATEs, STARVE_LIMIT = 4:
  - Issue order is S,S,S,S,C,S,S,C.
  - snp_issued = 6, cpu_issued = 2.
- Push 5 CPU commands back-to-back while the cache holds processing high:
  - cpu_ready drops after the 4th accepted push; the 5th is not accepted until after the first pop.
- CPU cmd = 2 (illegal for CPU) followed by READ:
  - dropped = 1; only the READ reaches the cache.
- Cache model never raises processing:
  - After 8 cycles in WAIT_ACK, timeout_err = 1 and the FSM is back in IDLE.
  - The next queued command issues normally.
- Assert rst during WAIT_DONE with 3 entries queued:
  - Next cycle: FSM IDLE, cache_write = 0, FIFOs empty, all counters 0.
